abr_alert_req_arbiter: RTL and testbench
========================================

Name: abr_alert_req_arbiter

Overview:
- Shares one alert sender channel between NumSrc local event sources.
- Latches a pending bit per source event.
- Grants pending sources round-robin, one at a time. For each grant it drives the sender's alert_req_i until the sender returns its alert_ack_o pulse, then records the cause.
- A per-handshake watchdog flags a stalled channel, for example when the receiver holds a sigint condition.

Parameters:
NumSrc, 4, number of event sources; legal range 2..32.
TimeoutCycles, 1024, maximum number of cycles in Req before the watchdog fires; legal value >= 4.
GapCycles, 2, number of cycles alert_req_o stays low between two grants; legal value >= 1.
IdxW, $clog2(NumSrc), derived; width of the source index.

Ports:
clk_i  input  1  clock
rst_b  input  1  asynchronous active-low reset
event_i  input  NumSrc  per-source event; level or pulse, sampled every cycle
alert_req_o  output  1  to the sender's alert_req_i
alert_ack_i  input  1  from the sender's alert_ack_o; single-cycle pulse
pending_o  output  NumSrc  latched pending bits
grant_idx_o  output  IdxW  index of the source currently or last granted
busy_o  output  1  FSM is not in Idle
cause_o  output  IdxW  index of the last acknowledged source
cause_vld_o  output  1  one-cycle pulse when cause_o updates
ack_cnt_o  output  16  saturating count of acknowledged handshakes
timeout_o  output  1  sticky watchdog flag
timeout_clr_i  input  1  clears timeout_o

Behaviour:
- Reset values: all outputs 0; FSM in Idle; RR pointer 0; timer 0. Reset may assert at any time; it clears all state immediately, including in-flight grants.
- pending_q[i] update each cycle: next value = event_i[i] | (pending_q[i] & ~clr[i]).
  - clr[i] = 1 only when the FSM is in Req, grant_idx == i and alert_ack_i = 1.
  - A new event in the same cycle as that source's ack wins: the bit stays set.
- FSM states are Idle, Req and Gap. alert_req_o = (state_q == Req) and is registered.
- Idle:
  - If |pending_q, select the first set bit searching upward, with wrap-around, from the RR pointer.
  - Load grant_idx with that index, clear the timer, go to Req.
  - With no pending bits, stay in Idle.
  - Latency: event at cycle t gives pending_o at t+1 and alert_req_o at t+2.
- Req:
  - Timer increments every cycle.
  - On alert_ack_i: clear pending[grant_idx]; cause_o <= grant_idx; pulse cause_vld_o; increment ack_cnt_o, saturating at 16'hFFFF; RR pointer <= grant_idx+1, mod NumSrc; go to Gap.
  - Else, if timer == TimeoutCycles-1: set timeout_o; leave the pending bit set; advance the RR pointer as above so other sources are not starved; go to Gap.
  - Ack takes priority over timeout in the same cycle.
- Gap:
  - Counts GapCycles cycles with alert_req_o = 0, then goes to Idle.
  - Purpose: the sender sees the request deasserted and does not re-trigger a handshake for an already-cleared source.
- alert_ack_i in Idle or Gap is ignored: no counter, cause or pending change.
- timeout_o: set has priority over timeout_clr_i in the same cycle.
- grant_idx_o holds its value outside Req.
- Round-robin guarantee: with all sources pending, each source is granted once every NumSrc handshakes.
- NumSrc that is not a power of two: the RR pointer wrap is explicit, with no out-of-range index.

Test Plan:
- Reset, then a 1-cycle pulse on event_i[2] with the ack model returning a pulse 5 cycles after alert_req_o rises:
  - Required: pending_o=4'b0100 at t+1; alert_req_o=1 at t+2; grant_idx_o=2.
  - On ack: cause_o=2, cause_vld_o pulses once, ack_cnt_o=1, pending_o=0.
  - alert_req_o low for exactly 2 cycles, then the FSM stays in Idle.
- event_i=4'b1111 held for 1 cycle, immediate acks:
  - Required grant order 0,1,2,3; ack_cnt_o=4; pending_o=0 afterwards.
- event_i[1] pulsed again in the same cycle as the ack for source 1:
  - Required: pending_o[1] stays 1 and source 1 is re-granted after the remaining sources in RR order.
- TimeoutCycles=8, no ack, event_i=4'b0011:
  - Required: timeout_o=1 after 8 Req cycles; source 0 still pending; source 1 granted next.
  - timeout_clr_i pulse then gives timeout_o=0.
- rst_b asserted mid-Req with pending=4'b1010:
  - Required: alert_req_o=0, pending_o=0, busy_o=0 asynchronously.
  - No grant after release until a new event arrives.
- Stray alert_ack_i pulse in Idle, and 70000 back-to-back handshakes:
  - Required: the stray pulse causes no state change; ack_cnt_o saturates at 16'hFFFF.

Source files
------------

// File: rtl/abr_alert_req_arbiter.sv
// Round-robin arbiter sharing one alert sender channel between NumSrc event
// sources: latches per-source pending bits, runs one req/ack handshake per
// grant, records the acknowledged cause and watches each handshake for stalls.
module abr_alert_req_arbiter #(
    parameter int unsigned NumSrc        = 4,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned GapCycles     = 2,
    localparam int unsigned IdxW         = $clog2(NumSrc)
) (
    input  logic              clk_i,
    input  logic              rst_b,
    input  logic [NumSrc-1:0] event_i,
    output logic              alert_req_o,
    input  logic              alert_ack_i,
    output logic [NumSrc-1:0] pending_o,
    output logic [IdxW-1:0]   grant_idx_o,
    output logic              busy_o,
    output logic [IdxW-1:0]   cause_o,
    output logic              cause_vld_o,
    output logic [15:0]       ack_cnt_o,
    output logic              timeout_o,
    input  logic              timeout_clr_i
);

    localparam int unsigned TmrW = $clog2(TimeoutCycles);
    localparam int unsigned GapW = (GapCycles > 1) ? $clog2(GapCycles) : 1;

    localparam logic [TmrW-1:0] TmrLast = TmrW'(TimeoutCycles - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GapCycles - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NumSrc - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP
    } state_e;

    state_e            state_q;
    logic [NumSrc-1:0] pending_q;
    logic [IdxW-1:0]   grant_idx_q;
    logic [IdxW-1:0]   rr_ptr_q;
    logic [TmrW-1:0]   timer_q;
    logic [GapW-1:0]   gap_q;
    logic              req_q;
    logic              busy_q;
    logic [IdxW-1:0]   cause_q;
    logic              cause_vld_q;
    logic [15:0]       ack_cnt_q;
    logic              timeout_q;

    logic [NumSrc-1:0] clr;
    logic              sel_vld;
    logic [IdxW-1:0]   sel_idx;
    logic [IdxW-1:0]   rr_next;
    int unsigned       cand;

    // Pointer wraps explicitly so non power-of-two NumSrc never yields an out-of-range index.
    assign rr_next = (grant_idx_q == IdxLast) ? '0 : grant_idx_q + IdxW'(1);

    // Only an ack seen during Req clears the granted source's pending bit.
    always_comb begin
        clr = '0;
        if (state_q == ST_REQ && alert_ack_i) begin
            clr[grant_idx_q] = 1'b1;
        end
    end

    // First pending source searching upward from the RR pointer, wrapping at NumSrc.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NumSrc; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NumSrc) begin
                cand = cand - NumSrc;
            end
            if (!sel_vld && pending_q[IdxW'(cand)]) begin
                sel_vld = 1'b1;
                sel_idx = IdxW'(cand);
            end
        end
    end

    // Grant FSM with pending latches, cause/count recording and sticky watchdog.
    always_ff @(posedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            timer_q     <= '0;
            gap_q       <= '0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            cause_q     <= '0;
            cause_vld_q <= 1'b0;
            ack_cnt_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            // A fresh event in the ack cycle keeps the bit set.
            pending_q   <= event_i | (pending_q & ~clr);
            cause_vld_q <= 1'b0;
            if (timeout_clr_i) begin
                timeout_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (sel_vld) begin
                        grant_idx_q <= sel_idx;
                        timer_q     <= '0;
                        state_q     <= ST_REQ;
                        req_q       <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (alert_ack_i) begin
                        cause_q     <= grant_idx_q;
                        cause_vld_q <= 1'b1;
                        if (ack_cnt_q != 16'hFFFF) begin
                            ack_cnt_q <= ack_cnt_q + 16'd1;
                        end
                        rr_ptr_q <= rr_next;
                        gap_q    <= '0;
                        state_q  <= ST_GAP;
                        req_q    <= 1'b0;
                    end else if (timer_q == TmrLast) begin
                        // Stalled channel: keep the source pending but move on.
                        timeout_q <= 1'b1;
                        rr_ptr_q  <= rr_next;
                        gap_q     <= '0;
                        state_q   <= ST_GAP;
                        req_q     <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TmrW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_q == GapLast) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q + GapW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign alert_req_o = req_q;
    assign pending_o   = pending_q;
    assign grant_idx_o = grant_idx_q;
    assign busy_o      = busy_q;
    assign cause_o     = cause_q;
    assign cause_vld_o = cause_vld_q;
    assign ack_cnt_o   = ack_cnt_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_abr_alert_req_arbiter.sv
// Scoreboard bench for abr_alert_req_arbiter: a set/pointer reference model
// predicts grants and acknowledged causes, a monitor compares on each output.
module tb_abr_alert_req_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 8;
    localparam int unsigned GP = 2;
    localparam int unsigned IW = 2;

    logic          clk_i = 1'b0;
    logic          rst_b = 1'b0;
    logic [N-1:0]  event_i = '0;
    logic          alert_req_o;
    logic          alert_ack_i;
    logic [N-1:0]  pending_o;
    logic [IW-1:0] grant_idx_o;
    logic          busy_o;
    logic [IW-1:0] cause_o;
    logic          cause_vld_o;
    logic [15:0]   ack_cnt_o;
    logic          timeout_o;
    logic          timeout_clr_i = 1'b0;

    always #5 clk_i = ~clk_i;

    abr_alert_req_arbiter #(.NumSrc(N), .TimeoutCycles(TO), .GapCycles(GP)) dut (
        .clk_i(clk_i), .rst_b(rst_b), .event_i(event_i), .alert_req_o(alert_req_o),
        .alert_ack_i(alert_ack_i), .pending_o(pending_o), .grant_idx_o(grant_idx_o),
        .busy_o(busy_o), .cause_o(cause_o), .cause_vld_o(cause_vld_o),
        .ack_cnt_o(ack_cnt_o), .timeout_o(timeout_o), .timeout_clr_i(timeout_clr_i)
    );

    // Second instance on a fast clock for the counter saturation run.
    logic        clk_f = 1'b0;
    logic        s_rst = 1'b0;
    logic [1:0]  s_ev  = '0;
    logic        s_ack = 1'b0;
    logic        s_req, s_busy, s_cvld, s_to;
    logic [1:0]  s_pend;
    logic        s_gidx, s_cause;
    logic [15:0] s_cnt;
    bit          sat_done = 1'b0;
    int          s_n = 0;

    always #1 clk_f = ~clk_f;

    abr_alert_req_arbiter #(.NumSrc(2), .TimeoutCycles(8), .GapCycles(1)) dut_sat (
        .clk_i(clk_f), .rst_b(s_rst), .event_i(s_ev), .alert_req_o(s_req),
        .alert_ack_i(s_ack), .pending_o(s_pend), .grant_idx_o(s_gidx),
        .busy_o(s_busy), .cause_o(s_cause), .cause_vld_o(s_cvld),
        .ack_cnt_o(s_cnt), .timeout_o(s_to), .timeout_clr_i(1'b0)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] p, input int start);
        for (int k = 0; k < N; k++) begin
            if (p[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    typedef struct packed {
        logic [IW-1:0] cause;
        logic [15:0]   cnt;
    } exp_t;

    // Reference model state.
    exp_t         q[$];
    logic [N-1:0] m_pend, m_pend_before, m_clrm;
    int           m_rr, m_cnt, m_reqc, m_grant;
    bit           m_to, m_req_old, m_ack_hit, m_to_hit;
    exp_t         m_e;

    // Monitor state.
    bit   req_prev;
    int   gap_run, vld_cnt;
    int   glog[$];
    exp_t mon_e;

    // Ack responder controls.
    bit ack_en = 1'b0, rand_delay = 1'b0, stray = 1'b0;
    int fix_delay = 0, ack_delay = 0, ack_wait = 0;

    // Reference model: pending set, RR pointer, handshake count, watchdog flag.
    always @(posedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
            m_pend = '0; m_pend_before = '0; m_rr = 0; m_cnt = 0; m_reqc = 0; m_to = 0;
            q.delete();
        end else begin
            m_req_old = alert_req_o;
            m_ack_hit = m_req_old && alert_ack_i;
            m_to_hit  = 1'b0;
            m_clrm    = '0;
            if (m_ack_hit) begin
                m_clrm[m_grant] = 1'b1;
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                m_e.cause = IW'(m_grant);
                m_e.cnt   = 16'(m_cnt);
                q.push_back(m_e);
                m_rr = (m_grant + 1) % N;
                m_reqc = 0;
            end else if (m_req_old) begin
                m_reqc++;
                if (m_reqc == TO) begin
                    m_to_hit = 1'b1;
                    m_rr = (m_grant + 1) % N;
                    m_reqc = 0;
                end
            end else begin
                m_reqc = 0;
            end
            if (m_to_hit) m_to = 1'b1;
            else if (timeout_clr_i) m_to = 1'b0;
            m_pend_before = m_pend;
            m_pend = event_i | (m_pend & ~m_clrm);
        end
    end

    // Monitor: checks grants, pending, watchdog, gap length and scoreboard pops.
    always @(negedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
            req_prev = 1'b0; gap_run = 0; m_grant = 0;
        end else begin
            if (alert_req_o && !req_prev) begin
                m_grant = rr_pick(m_pend_before, m_rr);
                glog.push_back(int'(grant_idx_o));
                chk("grant", grant_idx_o, m_grant);
            end
            if (busy_o && !alert_req_o) begin
                gap_run++;
            end else if (gap_run > 0) begin
                chk("gap_len", gap_run, GP);
                gap_run = 0;
            end
            chk("pending", pending_o, m_pend);
            chk("timeout", timeout_o, m_to);
            if (cause_vld_o) begin
                vld_cnt++;
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL cause_vld: got unexpected pulse cause %0d, required none", cause_o);
                end else begin
                    mon_e = q.pop_front();
                    chk("cause", cause_o, mon_e.cause);
                    chk("ack_cnt", ack_cnt_o, mon_e.cnt);
                end
            end
            req_prev = alert_req_o;
        end
    end

    // Sender model: acks ack_delay cycles into Req, or a stray pulse when idle.
    initial begin
        alert_ack_i = 1'b0;
        forever begin
            @(negedge clk_i);
            alert_ack_i = 1'b0;
            if (!rst_b) begin
                ack_wait = 0;
            end else if (stray) begin
                if (!alert_req_o) alert_ack_i = 1'b1;
                stray = 1'b0;
            end else if (!alert_req_o) begin
                ack_wait = 0;
                ack_delay = rand_delay ? int'($urandom_range(0, 9)) : fix_delay;
            end else if (ack_en) begin
                if (ack_wait >= ack_delay) begin
                    alert_ack_i = 1'b1;
                    ack_wait = 0;
                    ack_delay = 99;
                end else begin
                    ack_wait++;
                end
            end
        end
    end

    // Saturation run: both sources always pending, every request acked at once.
    initial begin
        repeat (3) @(negedge clk_f);
        s_rst = 1'b1;
        s_ev  = 2'b11;
        for (int i = 0; i < 400000 && s_n < 70000; i++) begin
            @(negedge clk_f);
            s_ack = s_req;
        end
        s_ev = '0;
        s_ack = 1'b0;
        sat_done = 1'b1;
    end

    always @(negedge clk_f) begin
        if (s_rst && s_cvld) begin
            s_n++;
            if (s_n % 5000 == 0 || (s_n >= 65530 && s_n <= 65540))
                chk("sat_cnt", s_cnt, (s_n > 65535) ? 65535 : s_n);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "time limit");
    end

    task automatic do_reset();
        @(negedge clk_i);
        #2;
        rst_b = 1'b0; event_i = '0; timeout_clr_i = 1'b0; ack_en = 1'b0;
        #1;
        chk("rst_req", alert_req_o, 0);
        chk("rst_pend", pending_o, 0);
        chk("rst_grant", grant_idx_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cause", cause_o, 0);
        chk("rst_vld", cause_vld_o, 0);
        chk("rst_cnt", ack_cnt_o, 0);
        chk("rst_to", timeout_o, 0);
        @(negedge clk_i);
        glog.delete();
        vld_cnt = 0;
        rst_b = 1'b1;
    endtask

    task automatic wait_rise(input string nm);
        int i;
        i = 0;
        do begin
            @(negedge clk_i);
            i++;
        end while (!alert_req_o && i < 100);
        if (!alert_req_o) begin
            tests++; fails++;
            $display("FAIL %s: alert_req_o got 0 after budget, required 1", nm);
        end
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int i;
        i = 0;
        do begin
            @(negedge clk_i);
            i++;
        end while ((busy_o || alert_req_o || pending_o != '0) && i < budget);
        if (busy_o || pending_o != '0) begin
            tests++; fails++;
            $display("FAIL %s: got busy %0d pending %0d after budget, required idle", nm, busy_o, pending_o);
        end
    endtask

    initial begin
        int exp2[4];
        int exp3[5];
        int cnt;
        bit done;
        exp2 = '{0, 1, 2, 3};
        exp3 = '{0, 1, 2, 3, 1};

        // Single pulse on source 2, ack five cycles into the request.
        do_reset();
        fix_delay = 5; ack_en = 1'b1;
        @(negedge clk_i); event_i = 4'b0100;
        @(negedge clk_i); event_i = '0;
        chk("t1_pend_t1", pending_o, 4'b0100);
        chk("t1_req_t1", alert_req_o, 0);
        @(negedge clk_i);
        chk("t1_req_t2", alert_req_o, 1);
        chk("t1_grant", grant_idx_o, 2);
        wait_idle("t1_idle", 60);
        chk("t1_cnt", ack_cnt_o, 1);
        chk("t1_cause", cause_o, 2);
        chk("t1_vld_pulses", vld_cnt, 1);
        repeat (4) @(negedge clk_i);
        chk("t1_stay_idle", {busy_o, alert_req_o}, 0);

        // All four sources at once, immediate acks.
        do_reset();
        fix_delay = 0; ack_en = 1'b1;
        @(negedge clk_i); event_i = 4'b1111;
        @(negedge clk_i); event_i = '0;
        wait_idle("t2_idle", 100);
        chk("t2_glen", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("t2_order", glog[i], exp2[i]);
        chk("t2_cnt", ack_cnt_o, 4);
        chk("t2_pend", pending_o, 0);

        // Re-event on source 1 in its own ack cycle.
        do_reset();
        fix_delay = 0; ack_en = 1'b1;
        @(negedge clk_i); event_i = 4'b1111;
        @(negedge clk_i); event_i = '0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk_i);
            if (alert_req_o && grant_idx_o == 1) begin
                event_i = 4'b0010;
                done = 1'b1;
                @(negedge clk_i);
                event_i = '0;
                chk("t3_pend1_kept", pending_o[1], 1);
            end
        end
        chk("t3_found", done, 1);
        wait_idle("t3_idle", 120);
        chk("t3_glen", glog.size(), 5);
        for (int i = 0; i < 5 && i < glog.size(); i++) chk("t3_order", glog[i], exp3[i]);
        chk("t3_cnt", ack_cnt_o, 5);

        // Watchdog: no ack on sources 0 and 1.
        do_reset();
        fix_delay = 0; ack_en = 1'b0;
        @(negedge clk_i); event_i = 4'b0011;
        @(negedge clk_i); event_i = '0;
        wait_rise("t4_rise0");
        chk("t4_grant0", grant_idx_o, 0);
        cnt = 1;
        for (int i = 0; i < 50 && alert_req_o; i++) begin
            @(negedge clk_i);
            if (alert_req_o) cnt++;
        end
        chk("t4_req_cycles", cnt, TO);
        chk("t4_timeout", timeout_o, 1);
        chk("t4_pend0", pending_o[0], 1);
        wait_rise("t4_rise1");
        chk("t4_grant1", grant_idx_o, 1);
        ack_en = 1'b1;
        wait_idle("t4_idle", 100);
        chk("t4_to_sticky", timeout_o, 1);
        timeout_clr_i = 1'b1;
        @(negedge clk_i);
        timeout_clr_i = 1'b0;
        chk("t4_to_clr", timeout_o, 0);

        // Asynchronous reset in the middle of a request.
        do_reset();
        ack_en = 1'b0;
        @(negedge clk_i); event_i = 4'b1010;
        @(negedge clk_i); event_i = '0;
        wait_rise("t5_rise");
        chk("t5_grant", grant_idx_o, 1);
        chk("t5_pend", pending_o, 4'b1010);
        #2;
        rst_b = 1'b0;
        #1;
        chk("t5_req_async", alert_req_o, 0);
        chk("t5_pend_async", pending_o, 0);
        chk("t5_busy_async", busy_o, 0);
        @(negedge clk_i);
        rst_b = 1'b1;
        glog.delete();
        repeat (10) @(negedge clk_i);
        chk("t5_no_grant", {busy_o, alert_req_o}, 0);
        chk("t5_glen", glog.size(), 0);

        // Stray ack while idle.
        stray = 1'b1;
        repeat (4) @(negedge clk_i);
        chk("t6_cnt", ack_cnt_o, m_cnt);
        chk("t6_busy", busy_o, 0);
        chk("t6_vld", vld_cnt, 0);

        // Randomised traffic, random ack latency including timeouts and clears.
        rand_delay = 1'b1; ack_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk_i);
            event_i = ($urandom_range(0, 6) == 0) ? N'($urandom) : '0;
            timeout_clr_i = ($urandom_range(0, 30) == 0);
        end
        event_i = '0; timeout_clr_i = 1'b0;
        rand_delay = 1'b0; fix_delay = 0;
        wait_idle("t7_drain", 300);
        chk("t7_sb_empty", q.size(), 0);

        // Saturation results.
        for (int i = 0; i < 60000 && !sat_done; i++) @(negedge clk_i);
        chk("sat_done", sat_done, 1);
        chk("sat_final", s_cnt, 16'hFFFF);
        chk("sat_handshakes", s_n >= 70000, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
